// File: rtl/gmii_udp_rx.sv
// GMII receive path: strips preamble/SFD, filters Ethernet II/IPv4/UDP to this board and streams the payload.
// Payload bytes appear one cycle after sampling, rx_done one cycle after rxdv drops; no backpressure (1 byte/cycle).
module gmii_udp_rx #(
  parameter logic [47:0] BOARD_MAC  = 48'h00_11_22_33_44_55,
  parameter logic [31:0] BOARD_IP   = {8'd192, 8'd168, 8'd1, 8'd10},
  parameter logic [15:0] LOCAL_PORT = 16'd1234
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  gmii_rxd,
  input  logic        gmii_rxdv,
  input  logic        gmii_rxer,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_sof,
  output logic        rx_eof,
  output logic [15:0] rx_len,
  output logic        rx_done,
  output logic        rx_crc_ok,
  output logic [47:0] pc_mac,
  output logic [31:0] pc_ip,
  output logic [15:0] pc_port
);

  typedef enum logic [2:0] {
    IDLE, PREAMBLE, ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, WAIT_END
  } state_t;

  state_t          state, state_nxt;
  logic [15:0]     cnt, udp_len, pay_len;
  logic            board_ok, bcast_ok, board_ok_nxt, bcast_ok_nxt;
  logic            blocked, accepted, err_seen;
  logic [47:0]     cand_mac;
  logic [31:0]     cand_ip;
  logic [15:0]     cand_port;
  logic [3:0][7:0] pipe;
  logic [2:0]      pipe_cnt;
  logic [31:0]     crc_acc;
  logic [7:0]      mac_byte, ip_byte, port_byte;
  logic            sfd, in_frame, frame_end, fcs_ok, good_end;

  function automatic logic [31:0] crc32(input logic [31:0] crc, input logic [7:0] d);
    logic [31:0] c;
    c = crc ^ {24'd0, d};
    for (int i = 0; i < 8; i++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    return c;
  endfunction

  assign mac_byte  = 8'(BOARD_MAC >> {3'd5 - cnt[2:0], 3'b000});
  assign ip_byte   = 8'(BOARD_IP >> {2'd3 - cnt[1:0], 3'b000});
  assign port_byte = cnt[0] ? LOCAL_PORT[7:0] : LOCAL_PORT[15:8];
  assign pay_len   = udp_len - 16'd8;
  assign sfd       = (state == PREAMBLE) && gmii_rxdv && (gmii_rxd == 8'hD5);
  assign in_frame  = gmii_rxdv && (state inside {ETH_HDR, IP_HDR, UDP_HDR, PAYLOAD, WAIT_END});
  assign frame_end = !gmii_rxdv && (state != IDLE);
  // The accumulator is kept un-inverted; the transmitted FCS is its complement, low byte first.
  assign fcs_ok    = ({pipe[0], pipe[1], pipe[2], pipe[3]} == ~crc_acc);
  assign good_end  = accepted && fcs_ok && !err_seen && (state != PAYLOAD);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    board_ok_nxt = board_ok;
    bcast_ok_nxt = bcast_ok;
    case (state)
      IDLE:     if (gmii_rxdv && !blocked) state_nxt = PREAMBLE;
      PREAMBLE: begin
        if (gmii_rxd == 8'hD5)      state_nxt = ETH_HDR;
        else if (gmii_rxd != 8'h55) state_nxt = WAIT_END;
      end
      ETH_HDR: begin
        if (cnt < 16'd6) begin
          board_ok_nxt = (cnt == 16'd0 || board_ok) && (gmii_rxd == mac_byte);
          bcast_ok_nxt = (cnt == 16'd0 || bcast_ok) && (gmii_rxd == 8'hFF);
          if (!board_ok_nxt && !bcast_ok_nxt) state_nxt = WAIT_END;
        end else if (cnt == 16'd12 && gmii_rxd != 8'h08) begin
          state_nxt = WAIT_END;
        end else if (cnt == 16'd13) begin
          state_nxt = (gmii_rxd == 8'h00) ? IP_HDR : WAIT_END;
        end
      end
      IP_HDR: begin
        if ((cnt == 16'd0 && gmii_rxd != 8'h45) ||
            (cnt == 16'd9 && gmii_rxd != 8'd17) ||
            (cnt >= 16'd16 && gmii_rxd != ip_byte))
          state_nxt = WAIT_END;
        else if (cnt == 16'd19)
          state_nxt = UDP_HDR;
      end
      UDP_HDR: begin
        if ((cnt == 16'd2 || cnt == 16'd3) && gmii_rxd != port_byte)
          state_nxt = WAIT_END;
        else if (cnt == 16'd7)
          state_nxt = (udp_len > 16'd8) ? PAYLOAD : WAIT_END;
      end
      PAYLOAD:  if (cnt + 16'd1 == pay_len) state_nxt = WAIT_END;
      default: ;
    endcase
    if (frame_end) state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_sof    <= 1'b0;
      rx_eof    <= 1'b0;
      rx_len    <= '0;
      rx_done   <= 1'b0;
      rx_crc_ok <= 1'b0;
      pc_mac    <= '0;
      pc_ip     <= '0;
      pc_port   <= '0;
      cnt       <= '0;
      board_ok  <= 1'b0;
      bcast_ok  <= 1'b0;
      blocked   <= 1'b1;
      accepted  <= 1'b0;
      err_seen  <= 1'b0;
      cand_mac  <= '0;
      cand_ip   <= '0;
      cand_port <= '0;
      udp_len   <= '0;
      pipe      <= '0;
      pipe_cnt  <= '0;
      crc_acc   <= 32'hFFFF_FFFF;
    end else begin
      rx_valid  <= 1'b0;
      rx_sof    <= 1'b0;
      rx_eof    <= 1'b0;
      rx_done   <= 1'b0;
      rx_crc_ok <= 1'b0;
      cnt       <= (state_nxt != state) ? 16'd0 : cnt + 16'd1;
      board_ok  <= board_ok_nxt;
      bcast_ok  <= bcast_ok_nxt;
      // A frame cut by reset is ignored until the line goes idle.
      if (!gmii_rxdv) blocked <= 1'b0;

      if (sfd) begin
        crc_acc  <= 32'hFFFF_FFFF;
        pipe     <= '0;
        pipe_cnt <= '0;
        err_seen <= 1'b0;
        accepted <= 1'b0;
      end
      if (in_frame) begin
        pipe <= {pipe[2:0], gmii_rxd};
        if (pipe_cnt != 3'd4) pipe_cnt <= pipe_cnt + 3'd1;
        else                  crc_acc  <= crc32(crc_acc, pipe[3]);
        if (gmii_rxer) err_seen <= 1'b1;
      end

      if (gmii_rxdv) begin
        if (state == ETH_HDR && cnt >= 16'd6 && cnt <= 16'd11) cand_mac  <= {cand_mac[39:0], gmii_rxd};
        if (state == IP_HDR && cnt >= 16'd12 && cnt <= 16'd15) cand_ip   <= {cand_ip[23:0], gmii_rxd};
        if (state == UDP_HDR && cnt <= 16'd1)                  cand_port <= {cand_port[7:0], gmii_rxd};
        if (state == UDP_HDR && (cnt == 16'd4 || cnt == 16'd5)) udp_len  <= {udp_len[7:0], gmii_rxd};
        if (state == UDP_HDR && cnt == 16'd7 && udp_len >= 16'd8) begin
          accepted <= 1'b1;
          rx_len   <= pay_len;
        end
        if (state == PAYLOAD) begin
          rx_valid <= 1'b1;
          rx_data  <= gmii_rxd;
          rx_sof   <= (cnt == 16'd0);
          rx_eof   <= (cnt + 16'd1 == pay_len);
        end
      end

      if (frame_end) begin
        rx_done   <= accepted;
        rx_crc_ok <= good_end;
        accepted  <= 1'b0;
        if (good_end) begin
          pc_mac  <= cand_mac;
          pc_ip   <= cand_ip;
          pc_port <= cand_port;
        end
      end
    end
  end

endmodule

// File: tb/tb_gmii_udp_rx.sv
// Scoreboard bench for gmii_udp_rx: directed frames, expected payload/done events queued, monitor compares.
module tb_gmii_udp_rx;

  localparam logic [47:0] BMAC  = 48'h00_11_22_33_44_55;
  localparam logic [31:0] BIP   = 32'hC0A8_010A;
  localparam logic [15:0] BPORT = 16'd1234;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  gmii_rxd;
  logic        gmii_rxdv, gmii_rxer;
  logic [7:0]  rx_data;
  logic        rx_valid, rx_sof, rx_eof, rx_done, rx_crc_ok;
  logic [15:0] rx_len, pc_port;
  logic [47:0] pc_mac;
  logic [31:0] pc_ip;

  always #4 clk = ~clk;

  gmii_udp_rx dut (
    .clk(clk), .rst(rst), .gmii_rxd(gmii_rxd), .gmii_rxdv(gmii_rxdv), .gmii_rxer(gmii_rxer),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_sof(rx_sof), .rx_eof(rx_eof), .rx_len(rx_len),
    .rx_done(rx_done), .rx_crc_ok(rx_crc_ok), .pc_mac(pc_mac), .pc_ip(pc_ip), .pc_port(pc_port)
  );

  typedef struct packed {logic [7:0] data; logic sof; logic eof; logic [15:0] len;} byte_exp_t;
  typedef struct packed {logic ok; logic [47:0] mac; logic [31:0] ip; logic [15:0] port;} done_exp_t;

  byte_exp_t   byte_q[$];
  done_exp_t   done_q[$];
  logic [7:0]  frm[$];
  logic [7:0]  pay[$];
  logic [47:0] lrn_mac  = '0;
  logic [31:0] lrn_ip   = '0;
  logic [15:0] lrn_port = '0;
  int          n_cmp = 0;
  int          n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int b = 0; b < 8; b++) begin
      fb = r[0] ^ d[b];
      r  = r >> 1;
      if (fb) r = r ^ 32'hEDB8_8320;
    end
    return r;
  endfunction

  task automatic build(input logic [47:0] dmac, input logic [47:0] smac, input logic [31:0] dip,
                       input logic [31:0] sip, input logic [15:0] sport);
    logic [15:0] ulen, tlen;
    logic [31:0] c;
    ulen = 16'(8 + pay.size());
    tlen = 16'(28 + pay.size());
    frm.delete();
    for (int i = 0; i < 6; i++) frm.push_back(dmac[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) frm.push_back(smac[47-8*i -: 8]);
    frm.push_back(8'h08); frm.push_back(8'h00);
    frm.push_back(8'h45); frm.push_back(8'h00); frm.push_back(tlen[15:8]); frm.push_back(tlen[7:0]);
    frm.push_back(8'h00); frm.push_back(8'h00); frm.push_back(8'h40); frm.push_back(8'h00);
    frm.push_back(8'h40); frm.push_back(8'h11); frm.push_back(8'h00); frm.push_back(8'h00);
    for (int i = 0; i < 4; i++) frm.push_back(sip[31-8*i -: 8]);
    for (int i = 0; i < 4; i++) frm.push_back(dip[31-8*i -: 8]);
    frm.push_back(sport[15:8]); frm.push_back(sport[7:0]);
    frm.push_back(BPORT[15:8]); frm.push_back(BPORT[7:0]);
    frm.push_back(ulen[15:8]); frm.push_back(ulen[7:0]);
    frm.push_back(8'h00); frm.push_back(8'h00);
    foreach (pay[i]) frm.push_back(pay[i]);
    while (frm.size() < 60) frm.push_back(8'h00);
    c = 32'hFFFF_FFFF;
    foreach (frm[i]) c = crc_step(c, frm[i]);
    c = ~c;
    frm.push_back(c[7:0]); frm.push_back(c[15:8]); frm.push_back(c[23:16]); frm.push_back(c[31:24]);
  endtask

  task automatic drive(input logic [7:0] d, input logic dv, input logic r, input logic e);
    @(posedge clk);
    #1;
    gmii_rxd  = d;
    gmii_rxdv = dv;
    rst       = r;
    gmii_rxer = e;
  endtask

  task automatic send(input int cut = -1, input int rst_at = -1, input int err_at = -1, input int gap = 12);
    for (int i = 0; i < 7; i++) drive(8'h55, 1'b1, 1'b0, 1'b0);
    drive(8'hD5, 1'b1, 1'b0, 1'b0);
    foreach (frm[i]) begin
      if (i == cut) break;
      drive(frm[i], 1'b1, i == rst_at, i == err_at);
    end
    for (int i = 0; i < gap; i++) drive(8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic exp_pay(input int n);
    byte_exp_t e;
    for (int i = 0; i < n; i++) begin
      e.data = pay[i];
      e.sof  = (i == 0);
      e.eof  = (i == pay.size() - 1);
      e.len  = 16'(pay.size());
      byte_q.push_back(e);
    end
  endtask

  task automatic exp_done(input logic ok, input logic [47:0] m, input logic [31:0] ip, input logic [15:0] p);
    done_exp_t e;
    if (ok) begin
      lrn_mac  = m;
      lrn_ip   = ip;
      lrn_port = p;
    end
    e.ok = ok; e.mac = lrn_mac; e.ip = lrn_ip; e.port = lrn_port;
    done_q.push_back(e);
  endtask

  always @(negedge clk) begin
    byte_exp_t be;
    done_exp_t de;
    if (rx_valid) begin
      if (byte_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_byte: got %02h, expected no payload", rx_data);
      end else begin
        be = byte_q.pop_front();
        check("payload{data,sof,eof,len}", {rx_data, rx_sof, rx_eof, rx_len}, be);
      end
    end
    if (rx_done) begin
      if (done_q.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL unexpected_done: got crc_ok=%0b, expected no rx_done", rx_crc_ok);
      end else begin
        de = done_q.pop_front();
        check("done_crc_ok", rx_crc_ok, de.ok);
        check("done_pc_mac", pc_mac, de.mac);
        check("done_pc_ip", pc_ip, de.ip);
        check("done_pc_port", pc_port, de.port);
      end
    end
  end

  initial begin
    rst = 1'b1; gmii_rxd = '0; gmii_rxdv = 1'b0; gmii_rxer = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_rx_valid", rx_valid, 1'b0);
    check("reset_rx_done", rx_done, 1'b0);
    check("reset_rx_len", rx_len, 16'd0);
    check("reset_pc_mac", pc_mac, 48'd0);
    check("reset_pc_ip", pc_ip, 32'd0);
    check("reset_pc_port", pc_port, 16'd0);

    // Basic frame, payload A1 B2 C3 D4 padded to minimum size.
    pay = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
    build(BMAC, 48'h02_00_00_00_00_01, BIP, 32'hC0A8_0102, 16'd5000);
    byte_q.push_back({8'hA1, 1'b1, 1'b0, 16'd4});
    byte_q.push_back({8'hB2, 1'b0, 1'b0, 16'd4});
    byte_q.push_back({8'hC3, 1'b0, 1'b0, 16'd4});
    byte_q.push_back({8'hD4, 1'b0, 1'b1, 16'd4});
    exp_done(1'b1, 48'h02_00_00_00_00_01, 32'hC0A8_0102, 16'd5000);
    send();
    check("t1_pc_ip", pc_ip, 32'hC0A8_0102);
    check("t1_pc_port", pc_port, 16'd5000);

    // Wrong destination IP: filtered out entirely.
    build(BMAC, 48'h02_00_00_00_00_09, 32'hC0A8_010B, 32'hC0A8_0109, 16'd9000);
    send();
    check("t2_pc_ip_kept", pc_ip, 32'hC0A8_0102);
    check("t2_pc_mac_kept", pc_mac, 48'h02_00_00_00_00_01);

    // Corrupted FCS: payload still streams, done with crc_ok low.
    build(BMAC, 48'h02_00_00_00_00_07, BIP, 32'hC0A8_0107, 16'd7007);
    frm[frm.size()-1] = frm[frm.size()-1] ^ 8'h01;
    exp_pay(4);
    exp_done(1'b0, '0, '0, '0);
    send();

    // Truncated after payload byte 2 of 16.
    pay.delete();
    for (int i = 0; i < 16; i++) pay.push_back(8'(8'h10 + i));
    build(BMAC, 48'h02_00_00_00_00_08, BIP, 32'hC0A8_0108, 16'd8008);
    exp_pay(2);
    exp_done(1'b0, '0, '0, '0);
    send(44);

    // Back-to-back frames with a single idle cycle.
    pay = '{8'h5A, 8'h3C};
    exp_pay(2);
    exp_done(1'b1, 48'h02_00_00_00_00_02, 32'hC0A8_0102, 16'd5000);
    exp_pay(2);
    exp_done(1'b1, 48'h02_00_00_00_00_03, 32'hC0A8_0102, 16'd5000);
    build(BMAC, 48'h02_00_00_00_00_02, BIP, 32'hC0A8_0102, 16'd5000);
    send(-1, -1, -1, 1);
    build(BMAC, 48'h02_00_00_00_00_03, BIP, 32'hC0A8_0102, 16'd5000);
    send();
    check("t5_pc_mac_second", pc_mac, 48'h02_00_00_00_00_03);

    // Broadcast destination, single-byte payload (sof and eof together).
    pay = '{8'h77};
    build(48'hFF_FF_FF_FF_FF_FF, 48'h02_00_00_00_00_04, BIP, 32'hC0A8_0103, 16'd7000);
    exp_pay(1);
    exp_done(1'b1, 48'h02_00_00_00_00_04, 32'hC0A8_0103, 16'd7000);
    send();

    // Empty UDP payload (length 8): accepted, nothing streamed.
    pay.delete();
    build(BMAC, 48'h02_00_00_00_00_05, BIP, 32'hC0A8_0104, 16'd6000);
    exp_done(1'b1, 48'h02_00_00_00_00_05, 32'hC0A8_0104, 16'd6000);
    send();

    // Receive error inside the IP header.
    pay = '{8'hE1, 8'hE2, 8'hE3};
    build(BMAC, 48'h02_00_00_00_00_06, BIP, 32'hC0A8_0106, 16'd6006);
    exp_pay(3);
    exp_done(1'b0, '0, '0, '0);
    send(-1, -1, 30);

    // Reset during IP header, then a clean frame.
    build(BMAC, 48'h02_00_00_00_00_0A, BIP, 32'hC0A8_010A, 16'd1010);
    lrn_mac = '0; lrn_ip = '0; lrn_port = '0;
    send(-1, 20);
    pay = '{8'h99, 8'h88, 8'h77, 8'h66, 8'h55};
    build(BMAC, 48'h02_00_00_00_00_0B, BIP, 32'hC0A8_0105, 16'd4321);
    exp_pay(5);
    exp_done(1'b1, 48'h02_00_00_00_00_0B, 32'hC0A8_0105, 16'd4321);
    send();

    repeat (10) @(negedge clk);
    check("leftover_payload_expectations", byte_q.size(), 0);
    check("leftover_done_expectations", done_q.size(), 0);
    check("final_pc_port", pc_port, 16'd4321);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
